alu_sequencer: RTL

Control-side partner of the 8-bit ALU. It takes operation requests over a valid/ready handshake and drives the ALU's alu_sel/a/b/carry_in. It captures the ALU result and flags into the accumulator (L), high register (H) and PSW. It also sequences the two-cycle 16-bit add (ADD then ADDC) and evaluates branch conditions from the PSW for the processor's control unit.

---
 rtl/alu_pkg.sv | 54 +++++
 rtl/alu_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its sequencer: op codes, flag bit
// positions, branch-condition encodings and the sequencer state type.
package alu_pkg;

    // Op codes the ALU executes directly
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_ADDC  = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SUBC  = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_CMP   = 4'b0111;
    localparam logic [3:0] OP_INR   = 4'b1000;
    localparam logic [3:0] OP_DCR   = 4'b1001;
    localparam logic [3:0] OP_RLC   = 4'b1010;

    // Op codes handled by the sequencer itself
    localparam logic [3:0] OP_ADD16 = 4'b1011;
    localparam logic [3:0] OP_LOAD  = 4'b1100;
    localparam logic [3:0] OP_LOADH = 4'b1101;

    // Select value parked on the ALU while nothing is executing
    localparam logic [3:0] OP_IDLE  = 4'b1111;

    // Flag bit positions, shared by alu_flags and the PSW
    localparam int FLG_P = 3;
    localparam int FLG_C = 2;
    localparam int FLG_S = 1;
    localparam int FLG_Z = 0;

    // Branch condition encodings for cond_sel
    localparam logic [2:0] COND_NZ = 3'b000;
    localparam logic [2:0] COND_Z  = 3'b001;
    localparam logic [2:0] COND_NC = 3'b010;
    localparam logic [2:0] COND_C  = 3'b011;
    localparam logic [2:0] COND_NP = 3'b100;
    localparam logic [2:0] COND_P  = 3'b101;
    localparam logic [2:0] COND_NS = 3'b110;
    localparam logic [2:0] COND_S  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_EXEC_LO,
        ST_EXEC_HI
    } seq_state_t;

    // True for op codes that the ALU computes (writeback from alu_result/flags)
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_RLC);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Control-side partner of the 8-bit ALU: accepts op requests, drives the ALU,
// writes results back into acc (L), acc_hi (H) and the PSW, chains the
// two-step 16-bit add and evaluates branch conditions from the PSW.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter logic [7:0] ACC_RESET = 8'h00,
    parameter logic [3:0] PSW_RESET = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_b,
    input  logic [7:0] req_b_hi,
    output logic [3:0] alu_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_cin,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic [7:0] acc_out,
    output logic [7:0] acc_hi_out,
    output logic [3:0] psw_out,
    input  logic [2:0] cond_sel,
    output logic       cond_true,
    output logic       done,
    output logic       err
);

    seq_state_t state;
    logic [7:0] acc;
    logic [7:0] acc_hi;
    logic [3:0] psw;
    logic [3:0] op_q;
    logic [7:0] b_q;
    logic [7:0] b_hi_q;
    logic       c16;

    assign req_ready  = (state == ST_IDLE);
    assign acc_out    = acc;
    assign acc_hi_out = acc_hi;
    assign psw_out    = psw;

    // Sequencer FSM: latch requests, write back ALU results, pulse done/err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            acc    <= ACC_RESET;
            acc_hi <= ACC_RESET;
            psw    <= PSW_RESET;
            op_q   <= '0;
            b_q    <= '0;
            b_hi_q <= '0;
            c16    <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q   <= req_op;
                        b_q    <= req_b;
                        b_hi_q <= req_b_hi;
                        state  <= (req_op == OP_ADD16) ? ST_EXEC_LO : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_alu_op(op_q)) begin
                        // CMP leaves the ALU result undefined, so only flags land
                        if (op_q != OP_CMP) begin
                            acc <= alu_result;
                        end
                        psw <= alu_flags;
                    end else if (op_q == OP_LOAD) begin
                        acc <= b_q;
                    end else if (op_q == OP_LOADH) begin
                        acc_hi <= b_q;
                    end else begin
                        err <= 1'b1;
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_EXEC_LO: begin
                    acc   <= alu_result;
                    c16   <= alu_flags[FLG_C];
                    state <= ST_EXEC_HI;
                end
                ST_EXEC_HI: begin
                    acc_hi     <= alu_result;
                    psw[FLG_C] <= alu_flags[FLG_C];
                    done       <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ALU operand/select drive for the current state; parked values when idle
    always_comb begin
        alu_sel = OP_IDLE;
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_cin = 1'b0;
        case (state)
            ST_EXEC: begin
                alu_sel = op_q;
                alu_a   = acc;
                alu_b   = b_q;
                alu_cin = psw[FLG_C];
            end
            ST_EXEC_LO: begin
                alu_sel = OP_ADD;
                alu_a   = acc;
                alu_b   = b_q;
                alu_cin = 1'b0;
            end
            ST_EXEC_HI: begin
                alu_sel = OP_ADDC;
                alu_a   = acc_hi;
                alu_b   = b_hi_q;
                alu_cin = c16;
            end
            default: ;
        endcase
    end

    // Branch condition evaluated straight from the PSW
    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            COND_NZ: cond_true = ~psw[FLG_Z];
            COND_Z:  cond_true =  psw[FLG_Z];
            COND_NC: cond_true = ~psw[FLG_C];
            COND_C:  cond_true =  psw[FLG_C];
            COND_NP: cond_true = ~psw[FLG_P];
            COND_P:  cond_true =  psw[FLG_P];
            COND_NS: cond_true = ~psw[FLG_S];
            COND_S:  cond_true =  psw[FLG_S];
            default: cond_true = 1'b0;
        endcase
    end

endmodule
